toy_bus_itcm_arb_ctrl: RTL and testbench

Two-requester round-robin arbiter and in-order ack router for the ITCM node of the toy bus. It grants one of two request channels to the single ITCM request port and holds the grant stable under backpressure. It records each issued request's source in an ordering FIFO and steers the ITCM's in-order ack stream back to the correct requester. It replaces tgt_id-based ack decoding at the arb_itcm node.

---
 rtl/toy_bus_itcm_arb_ctrl_if.sv | 46 ++++
 rtl/toy_bus_itcm_arb_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_toy_bus_itcm_arb_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_bus_itcm_arb_ctrl_if.sv
// Bus bundle for the ITCM arbitration node: two requester channels, the
// single ITCM request port, the ITCM ack port and the two routed ack
// channels. master = surrounding system (requesters + ITCM), slave = arbiter.
interface toy_bus_itcm_arb_ctrl_if #(
  parameter int REQ_W = 339,
  parameter int ACK_W = 275
);
  // requester request channels
  logic             in0_req_vld;
  logic             in0_req_rdy;
  logic [REQ_W-1:0] in0_req_pld;
  logic             in1_req_vld;
  logic             in1_req_rdy;
  logic [REQ_W-1:0] in1_req_pld;
  // ITCM request port
  logic             out0_req_vld;
  logic             out0_req_rdy;
  logic [REQ_W-1:0] out0_req_pld;
  // ITCM ack port
  logic             out0_ack_vld;
  logic             out0_ack_rdy;
  logic [ACK_W-1:0] out0_ack_pld;
  // routed ack channels
  logic             in0_ack_vld;
  logic             in0_ack_rdy;
  logic [ACK_W-1:0] in0_ack_pld;
  logic             in1_ack_vld;
  logic             in1_ack_rdy;
  logic [ACK_W-1:0] in1_ack_pld;

  modport master (
    output in0_req_vld, in0_req_pld, in1_req_vld, in1_req_pld,
    output out0_req_rdy, out0_ack_vld, out0_ack_pld,
    output in0_ack_rdy, in1_ack_rdy,
    input  in0_req_rdy, in1_req_rdy, out0_req_vld, out0_req_pld,
    input  out0_ack_rdy, in0_ack_vld, in0_ack_pld, in1_ack_vld, in1_ack_pld
  );

  modport slave (
    input  in0_req_vld, in0_req_pld, in1_req_vld, in1_req_pld,
    input  out0_req_rdy, out0_ack_vld, out0_ack_pld,
    input  in0_ack_rdy, in1_ack_rdy,
    output in0_req_rdy, in1_req_rdy, out0_req_vld, out0_req_pld,
    output out0_ack_rdy, in0_ack_vld, in0_ack_pld, in1_ack_vld, in1_ack_pld
  );
endinterface

// File: rtl/toy_bus_itcm_arb_ctrl.sv
// Two-requester round-robin arbiter with in-order ack routing for the ITCM
// node. The grant is held while the ITCM backpressures; every issued request
// records its source in a small ordering FIFO whose head steers the ITCM's
// in-order ack stream back to the right requester.
// Optional macro TOY_BUS_ITCM_ARB_ERR_EN adds the sticky err_unexp_ack output.
module toy_bus_itcm_arb_ctrl #(
  parameter int REQ_W = 339,
  parameter int ACK_W = 275,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  toy_bus_itcm_arb_ctrl_if.slave bus
`ifdef TOY_BUS_ITCM_ARB_ERR_EN
  ,
  output logic err_unexp_ack
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } arb_state_e;

  arb_state_e       state_q, state_d;
  logic             lock_idx_q, lock_idx_d;
  logic             last_q, last_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_mem [DEPTH];

  logic [1:0]       req_vld_vec;
  logic [1:0]       req_rdy_vec;
  logic [1:0]       ack_vld_vec;
  logic [1:0]       ack_rdy_vec;
  logic             full;
  logic             empty;
  logic             grant_idx;
  logic             has_grant;
  logic             issue;
  logic             req_hs;
  logic             ack_hs;
  logic             head_idx;
  logic [REQ_W-1:0] req_mux;
  logic [ACK_W-1:0] ack_pld;

  assign req_vld_vec = {bus.in1_req_vld, bus.in0_req_vld};
  assign ack_rdy_vec = {bus.in1_ack_rdy, bus.in0_ack_rdy};

  // Full/empty come from the registered count only, so a same-cycle pop
  // never lets a push through while full.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign head_idx = fifo_mem[rd_ptr_q];

  // Arbitration FSM: pick the grant, gate issue, and hold the grant while stalled
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    grant_idx  = ~last_q;
    has_grant  = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        // prefer the requester that was not served last
        if (req_vld_vec[~last_q]) begin
          grant_idx = ~last_q;
          has_grant = 1'b1;
        end else if (req_vld_vec[last_q]) begin
          grant_idx = last_q;
          has_grant = 1'b1;
        end
      end
      ST_LOCKED: begin
        grant_idx = lock_idx_q;
        has_grant = 1'b1;
      end
      default: begin
        grant_idx = ~last_q;
        has_grant = 1'b0;
      end
    endcase

    issue  = rst_n & has_grant & req_vld_vec[grant_idx] & ~full;
    req_hs = issue & bus.out0_req_rdy;

    case (state_q)
      ST_UNLOCKED: begin
        if (issue && !bus.out0_req_rdy) begin
          state_d    = ST_LOCKED;
          lock_idx_d = grant_idx;
        end
      end
      ST_LOCKED: begin
        if (req_hs) begin
          state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // Per-requester ready and routed ack valid; only the selected channel is live
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign req_rdy_vec[gi] = rst_n & has_grant & (grant_idx == 1'(gi)) &
                               bus.out0_req_rdy & ~full;
      assign ack_vld_vec[gi] = rst_n & ~empty & (head_idx == 1'(gi)) &
                               bus.out0_ack_vld;
    end
  endgenerate

  assign req_mux          = grant_idx ? bus.in1_req_pld : bus.in0_req_pld;
  assign bus.out0_req_vld = issue;
  assign bus.out0_req_pld = req_mux;
  assign bus.in0_req_rdy  = req_rdy_vec[0];
  assign bus.in1_req_rdy  = req_rdy_vec[1];

  assign ack_pld          = bus.out0_ack_pld;
  assign bus.out0_ack_rdy = rst_n & ~empty & ack_rdy_vec[head_idx];
  assign ack_hs           = bus.out0_ack_vld & bus.out0_ack_rdy;
  assign bus.in0_ack_vld  = ack_vld_vec[0];
  assign bus.in1_ack_vld  = ack_vld_vec[1];
  assign bus.in0_ack_pld  = ack_pld;
  assign bus.in1_ack_pld  = ack_pld;

  // Ordering FIFO bookkeeping: pointers wrap naturally, count tracks occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (req_hs) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      last_d   = grant_idx;
    end
    if (ack_hs) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({req_hs, ack_hs})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset makes in0 the first winner and empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNLOCKED;
      lock_idx_q <= 1'b0;
      last_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage needs no reset: entries are only read while count is non-zero
  always_ff @(posedge clk) begin
    if (req_hs) begin
      fifo_mem[wr_ptr_q] <= grant_idx;
    end
  end

`ifdef TOY_BUS_ITCM_ARB_ERR_EN
  logic err_q, err_d;

  // Sticky error: an ack with nothing outstanding, or a push into a full FIFO
  always_comb begin
    err_d = err_q | (bus.out0_ack_vld & empty) | (req_hs & full);
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_unexp_ack = err_q;
`endif

endmodule

// File: tb/tb_toy_bus_itcm_arb_ctrl.sv
// Randomized scoreboard bench for toy_bus_itcm_arb_ctrl. A transaction-level
// model predicts the expected response each cycle and queues it; an
// independent monitor on the falling edge pops and compares.
module tb_toy_bus_itcm_arb_ctrl;
  localparam int REQ_W = 339;
  localparam int ACK_W = 275;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  toy_bus_itcm_arb_ctrl_if #(.REQ_W(REQ_W), .ACK_W(ACK_W)) bus ();
`ifdef TOY_BUS_ITCM_ARB_ERR_EN
  logic err_unexp_ack;
`endif

  toy_bus_itcm_arb_ctrl #(.REQ_W(REQ_W), .ACK_W(ACK_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef TOY_BUS_ITCM_ARB_ERR_EN
    ,
    .err_unexp_ack (err_unexp_ack)
`endif
  );

  typedef struct {
    bit             out_vld;
    bit             rdy0;
    bit             rdy1;
    logic [REQ_W-1:0] pld;
    bit             avld0;
    bit             avld1;
    bit             ardy;
    bit             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // transaction-level reference state
  bit   last_m, lock_m, lock_idx_m, err_m, prev_rst_n;
  bit   outstanding[$];
  bit   hs_m[2];
  int   hs_log[$];
  int   ack_log[$];

  // stimulus knobs (percent)
  int p_v0, p_v1, p_ordy, p_avld, p_ardy0, p_ardy1;

  function automatic logic [REQ_W-1:0] rnd_req();
    logic [REQ_W-1:0] v = '0;
    for (int i = 0; i < 11; i++) v = {v[REQ_W-33:0], 32'($urandom())};
    return v;
  endfunction

  function automatic logic [ACK_W-1:0] rnd_ack();
    logic [ACK_W-1:0] v = '0;
    for (int i = 0; i < 9; i++) v = {v[ACK_W-33:0], 32'($urandom())};
    return v;
  endfunction

  function automatic bit roll(int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk_pld(string name, logic [REQ_W-1:0] act, logic [REQ_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_forced_zero(string tag);
    chk({tag, "_out0_req_vld"}, 64'(bus.out0_req_vld), 0);
    chk({tag, "_in0_req_rdy"},  64'(bus.in0_req_rdy), 0);
    chk({tag, "_in1_req_rdy"},  64'(bus.in1_req_rdy), 0);
    chk({tag, "_in0_ack_vld"},  64'(bus.in0_ack_vld), 0);
    chk({tag, "_in1_ack_vld"},  64'(bus.in1_ack_vld), 0);
    chk({tag, "_out0_ack_rdy"}, 64'(bus.out0_ack_rdy), 0);
  endtask

  // Requesters hold vld/payload until their handshake; everything else is free
  task automatic drive_inputs();
    if (!(bus.in0_req_vld && !hs_m[0])) begin
      bus.in0_req_vld = roll(p_v0);
      bus.in0_req_pld = rnd_req();
    end
    if (!(bus.in1_req_vld && !hs_m[1])) begin
      bus.in1_req_vld = roll(p_v1);
      bus.in1_req_pld = rnd_req();
    end
    bus.out0_req_rdy = roll(p_ordy);
    bus.out0_ack_vld = roll(p_avld);
    bus.out0_ack_pld = rnd_ack();
    bus.in0_ack_rdy  = roll(p_ardy0);
    bus.in1_ack_rdy  = roll(p_ardy1);
  endtask

  // Reference: round-robin winner that sticks while stalled; acks go to the
  // oldest outstanding requester.
  task automatic model_step();
    exp_t r;
    bit v[2];
    bit ardy[2];
    bit any, w, full, hs_req, hs_ack, h;
    if (!rst_n) begin
      if (prev_rst_n) check_forced_zero("rst_immediate");
      outstanding.delete();
      last_m = 1'b1; lock_m = 1'b0; lock_idx_m = 1'b0; err_m = 1'b0;
      hs_m[0] = 1'b0; hs_m[1] = 1'b0;
      prev_rst_n = rst_n;
      return;
    end
    prev_rst_n = rst_n;
    v[0] = bus.in0_req_vld; v[1] = bus.in1_req_vld;
    ardy[0] = bus.in0_ack_rdy; ardy[1] = bus.in1_ack_rdy;
    full = (outstanding.size() == DEPTH);
    if (lock_m) begin
      w = lock_idx_m; any = 1'b1;
    end else if (v[0] && v[1]) begin
      w = ~last_m; any = 1'b1;
    end else if (v[0] || v[1]) begin
      w = v[1]; any = 1'b1;
    end else begin
      w = 1'b0; any = 1'b0;
    end
    r.out_vld = any && v[w] && !full;
    r.rdy0 = any && (w == 1'b0) && bus.out0_req_rdy && !full;
    r.rdy1 = any && (w == 1'b1) && bus.out0_req_rdy && !full;
    r.pld  = w ? bus.in1_req_pld : bus.in0_req_pld;
    hs_req = r.out_vld && bus.out0_req_rdy;
    r.avld0 = 1'b0; r.avld1 = 1'b0; r.ardy = 1'b0; hs_ack = 1'b0;
    if (outstanding.size() > 0) begin
      h = outstanding[0];
      r.avld0 = bus.out0_ack_vld && (h == 1'b0);
      r.avld1 = bus.out0_ack_vld && (h == 1'b1);
      r.ardy  = ardy[h];
      hs_ack  = bus.out0_ack_vld && ardy[h];
    end
    r.err = err_m;
    if (bus.out0_ack_vld && outstanding.size() == 0) err_m = 1'b1;
    if (!lock_m && r.out_vld && !bus.out0_req_rdy) begin
      lock_m = 1'b1; lock_idx_m = w;
    end else if (lock_m && hs_req) begin
      lock_m = 1'b0;
    end
    hs_m[0] = hs_req && (w == 1'b0);
    hs_m[1] = hs_req && (w == 1'b1);
    if (hs_req) last_m = w;
    if (hs_ack) void'(outstanding.pop_front());
    if (hs_req) outstanding.push_back(w);
    exp_q.push_back(r);
  endtask

  task automatic cycle(bit rst_val);
    @(posedge clk);
    #1;
    rst_n = rst_val;
    drive_inputs();
    #1;
    model_step();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_knobs(int v0, int v1, int ordy, int avld, int ar0, int ar1);
    p_v0 = v0; p_v1 = v1; p_ordy = ordy; p_avld = avld; p_ardy0 = ar0; p_ardy1 = ar1;
  endtask

  // Monitor: compares DUT outputs against the queued prediction each cycle
  always @(negedge clk) begin
    exp_t r;
    if (!rst_n) begin
      check_forced_zero("in_reset");
    end else if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: got no prediction expected one per cycle");
    end else begin
      r = exp_q.pop_front();
      chk("out0_req_vld", 64'(bus.out0_req_vld), 64'(r.out_vld));
      chk("in0_req_rdy",  64'(bus.in0_req_rdy),  64'(r.rdy0));
      chk("in1_req_rdy",  64'(bus.in1_req_rdy),  64'(r.rdy1));
      if (r.out_vld) chk_pld("out0_req_pld", bus.out0_req_pld, r.pld);
      chk("in0_ack_vld",  64'(bus.in0_ack_vld),  64'(r.avld0));
      chk("in1_ack_vld",  64'(bus.in1_ack_vld),  64'(r.avld1));
      chk("out0_ack_rdy", 64'(bus.out0_ack_rdy), 64'(r.ardy));
      if (bus.out0_ack_vld) begin
        chk_pld("in0_ack_pld", REQ_W'(bus.in0_ack_pld), REQ_W'(bus.out0_ack_pld));
        chk_pld("in1_ack_pld", REQ_W'(bus.in1_ack_pld), REQ_W'(bus.out0_ack_pld));
      end
`ifdef TOY_BUS_ITCM_ARB_ERR_EN
      chk("err_unexp_ack", 64'(err_unexp_ack), 64'(r.err));
`endif
      if (bus.out0_req_vld && bus.out0_req_rdy) hs_log.push_back(bus.in1_req_rdy ? 1 : 0);
      if (bus.out0_ack_vld && bus.out0_ack_rdy) ack_log.push_back(bus.in1_ack_vld ? 1 : 0);
      $display("cyc t=%0t req_vld=%0b req_rdy=%0b%0b ack_vld=%0b%0b ack_rdy=%0b",
               $time, bus.out0_req_vld, bus.in1_req_rdy, bus.in0_req_rdy,
               bus.in1_ack_vld, bus.in0_ack_vld, bus.out0_ack_rdy);
    end
  end

  initial begin
    // inputs active during reset so the forced-zero checks mean something
    bus.in0_req_vld = 1'b1; bus.in0_req_pld = rnd_req();
    bus.in1_req_vld = 1'b1; bus.in1_req_pld = rnd_req();
    bus.out0_req_rdy = 1'b1; bus.out0_ack_vld = 1'b1; bus.out0_ack_pld = rnd_ack();
    bus.in0_ack_rdy = 1'b1; bus.in1_ack_rdy = 1'b1;
    last_m = 1'b1; lock_m = 1'b0; lock_idx_m = 1'b0; err_m = 1'b0; prev_rst_n = 1'b0;
    hs_m[0] = 1'b0; hs_m[1] = 1'b0;
    set_knobs(100, 100, 100, 100, 100, 100);
    repeat (3) cycle(1'b0);

    // alternation from reset, then the FIFO fills and the 5th request blocks
    set_knobs(100, 100, 100, 0, 100, 100);
    hs_log.delete(); ack_log.delete();
    repeat (6) cycle(1'b1);
    settle();
    chk("alt_grant_count", 64'(hs_log.size()), 4);
    for (int i = 0; i < 4; i++) if (i < hs_log.size()) chk("alt_grant_src", 64'(hs_log[i]), 64'(i % 2));
    chk("full_blocks_vld", 64'(bus.out0_req_vld), 0);
    chk("full_blocks_rdy0", 64'(bus.in0_req_rdy), 0);

    // one ack frees a slot; it goes to in0 and the blocked request issues next cycle
    set_knobs(100, 100, 100, 100, 100, 100);
    cycle(1'b1);
    p_avld = 0;
    repeat (2) cycle(1'b1);
    settle();
    chk("ack_count", 64'(ack_log.size()), 1);
    if (ack_log.size() > 0) chk("ack_dest", 64'(ack_log[0]), 0);
    chk("unblock_grant_count", 64'(hs_log.size()), 5);
    if (hs_log.size() > 4) chk("unblock_grant_src", 64'(hs_log[4]), 0);

    // backpressure for 3 cycles holds the in0 grant; in1 follows
    repeat (2) cycle(1'b0);
    hs_log.delete(); ack_log.delete();
    set_knobs(100, 100, 0, 0, 100, 100);
    repeat (3) cycle(1'b1);
    p_ordy = 100;
    repeat (2) cycle(1'b1);
    settle();
    chk("stall_grant_count", 64'(hs_log.size()), 2);
    if (hs_log.size() > 1) begin
      chk("stall_grant0", 64'(hs_log[0]), 0);
      chk("stall_grant1", 64'(hs_log[1]), 1);
    end

    // randomized traffic with varying pressure on every channel
    for (int blk = 0; blk < 25; blk++) begin
      set_knobs(int'($urandom_range(100)), int'($urandom_range(100)), int'($urandom_range(100)),
                int'($urandom_range(100)), int'($urandom_range(100)), int'($urandom_range(100)));
      repeat (100) cycle(1'b1);
    end

    // reset with requests outstanding; outputs drop at once, in0 wins afterwards
    set_knobs(100, 100, 100, 0, 100, 100);
    repeat (3) cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    hs_log.delete();
    cycle(1'b1);
    settle();
    chk("post_reset_grant_count", 64'(hs_log.size()), 1);
    if (hs_log.size() > 0) chk("post_reset_grant_src", 64'(hs_log[0]), 0);

    repeat (2) cycle(1'b1);
    settle();
    chk("sb_drained", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
